// File: rtl/conv_pkg.sv
// Shared dimension defaults, feeder FSM state type and a counter-width helper
// for the convolution stream feeder.
package conv_pkg;

  localparam int unsigned DEF_FEATURE_MAP_WIDTH  = 1024;
  localparam int unsigned DEF_FEATURE_MAP_HEIGHT = 1024;
  localparam int unsigned DEF_INPUT_NB_CHANNELS  = 64;
  localparam int unsigned DEF_OUTPUT_NB_CHANNELS = 64;
  localparam int unsigned DEF_KERNEL_SIZE        = 3;
  localparam int unsigned DEF_DATA_WIDTH         = 16;
  localparam int unsigned DEF_FM_ADDR_WIDTH      = 26;
  localparam int unsigned DEF_K_ADDR_WIDTH       = 16;

  typedef enum logic [1:0] {IDLE, STREAM, DRAIN, DONE} feeder_state_t;

  // Bits needed to count 0..n-1, never less than one.
  function automatic int unsigned cnt_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/feeder_skid_fifo.sv
// Two-entry FIFO holding {activation, weight} beats; accepts a push and a pop
// in the same cycle so a ready consumer can drain one beat per clock.
module feeder_skid_fifo #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             arst_n_in,
  input  logic             push,
  input  logic [WIDTH-1:0] wdata,
  input  logic             pop,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty
);

  logic [WIDTH-1:0] mem_q [2];
  logic             wr_ptr_q;
  logic             rd_ptr_q;
  logic [1:0]       count_q;
  logic             do_push;
  logic             do_pop;

  assign full    = (count_q == 2'd2);
  assign empty   = (count_q == 2'd0);
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign rdata   = mem_q[rd_ptr_q];

  always_ff @(posedge clk or negedge arst_n_in) begin
    if (!arst_n_in) begin
      mem_q[0] <= '0;
      mem_q[1] <= '0;
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      count_q  <= '0;
    end else begin
      if (do_push) begin
        mem_q[wr_ptr_q] <= wdata;
        wr_ptr_q        <= ~wr_ptr_q;
      end
      if (do_pop) rd_ptr_q <= ~rd_ptr_q;
      case ({do_push, do_pop})
        2'b10:   count_q <= count_q + 2'd1;
        2'b01:   count_q <= count_q - 2'd1;
        default: count_q <= count_q;
      endcase
    end
  end

endmodule

// File: rtl/conv_stream_feeder.sv
// Walks every (x, y, ch_in, ch_out, ky, kx) tap of a convolution, reads the
// activation and weight, and streams them as paired beats through a 2-entry FIFO.
module conv_stream_feeder
  import conv_pkg::*;
#(
  parameter int unsigned FEATURE_MAP_WIDTH  = DEF_FEATURE_MAP_WIDTH,
  parameter int unsigned FEATURE_MAP_HEIGHT = DEF_FEATURE_MAP_HEIGHT,
  parameter int unsigned INPUT_NB_CHANNELS  = DEF_INPUT_NB_CHANNELS,
  parameter int unsigned OUTPUT_NB_CHANNELS = DEF_OUTPUT_NB_CHANNELS,
  parameter int unsigned KERNEL_SIZE        = DEF_KERNEL_SIZE,
  parameter int unsigned DATA_WIDTH         = DEF_DATA_WIDTH,
  parameter int unsigned FM_ADDR_WIDTH      = DEF_FM_ADDR_WIDTH,
  parameter int unsigned K_ADDR_WIDTH       = DEF_K_ADDR_WIDTH
) (
  input  logic                     clk,
  input  logic                     arst_n_in,
  input  logic                     start,
  output logic                     busy,
  output logic                     done,
  output logic                     fm_re,
  output logic [FM_ADDR_WIDTH-1:0] fm_addr,
  input  logic [DATA_WIDTH-1:0]    fm_rdata,
  output logic                     k_re,
  output logic [K_ADDR_WIDTH-1:0]  k_addr,
  input  logic [DATA_WIDTH-1:0]    k_rdata,
  output logic                     a_valid,
  output logic                     b_valid,
  output logic [DATA_WIDTH-1:0]    a_data,
  output logic [DATA_WIDTH-1:0]    b_data,
  input  logic                     a_ready,
  input  logic                     b_ready
);

  // x/y counters are wide enough that x + K/2 never overflows the signed tap index.
  localparam int unsigned XW   = cnt_width(FEATURE_MAP_WIDTH + KERNEL_SIZE);
  localparam int unsigned YW   = cnt_width(FEATURE_MAP_HEIGHT + KERNEL_SIZE);
  localparam int unsigned CIW  = cnt_width(INPUT_NB_CHANNELS);
  localparam int unsigned COW  = cnt_width(OUTPUT_NB_CHANNELS);
  localparam int unsigned KW   = cnt_width(KERNEL_SIZE);
  localparam int unsigned HALF = KERNEL_SIZE / 2;

  feeder_state_t state_q, state_d;

  logic [XW-1:0]  x_q;
  logic [YW-1:0]  y_q;
  logic [CIW-1:0] ci_q;
  logic [COW-1:0] co_q;
  logic [KW-1:0]  ky_q, kx_q;
  logic x_last, y_last, ci_last, co_last, ky_last, kx_last;
  logic w_ky, w_co, w_ci, w_y, last_beat;

  logic signed [XW:0] xi;
  logic signed [YW:0] yi;
  logic               pad;
  logic [FM_ADDR_WIDTH-1:0] fm_addr_c;
  logic [K_ADDR_WIDTH-1:0]  k_addr_c;

  logic                    issue, slot_free, inflight_q, pad_q;
  logic [1:0]              occupancy;
  logic                    fifo_full, fifo_empty, fifo_pop;
  logic [DATA_WIDTH-1:0]   a_in;
  logic [2*DATA_WIDTH-1:0] fifo_head;

  assign kx_last = (kx_q == KW'(KERNEL_SIZE - 1));
  assign ky_last = (ky_q == KW'(KERNEL_SIZE - 1));
  assign co_last = (co_q == COW'(OUTPUT_NB_CHANNELS - 1));
  assign ci_last = (ci_q == CIW'(INPUT_NB_CHANNELS - 1));
  assign y_last  = (y_q == YW'(FEATURE_MAP_HEIGHT - 1));
  assign x_last  = (x_q == XW'(FEATURE_MAP_WIDTH - 1));

  assign w_ky      = kx_last;
  assign w_co      = w_ky && ky_last;
  assign w_ci      = w_co && co_last;
  assign w_y       = w_ci && ci_last;
  assign last_beat = w_y && y_last && x_last;

  assign xi  = $signed({1'b0, x_q}) + $signed({1'b0, XW'(kx_q)}) - $signed((XW+1)'(HALF));
  assign yi  = $signed({1'b0, y_q}) + $signed({1'b0, YW'(ky_q)}) - $signed((YW+1)'(HALF));
  assign pad = xi[XW] || (xi[XW-1:0] >= XW'(FEATURE_MAP_WIDTH)) ||
               yi[YW] || (yi[YW-1:0] >= YW'(FEATURE_MAP_HEIGHT));

  assign fm_addr_c = (FM_ADDR_WIDTH'(yi[YW-1:0]) * FM_ADDR_WIDTH'(FEATURE_MAP_WIDTH)
                      + FM_ADDR_WIDTH'(xi[XW-1:0])) * FM_ADDR_WIDTH'(INPUT_NB_CHANNELS)
                     + FM_ADDR_WIDTH'(ci_q);
  assign k_addr_c  = ((K_ADDR_WIDTH'(co_q) * K_ADDR_WIDTH'(INPUT_NB_CHANNELS) + K_ADDR_WIDTH'(ci_q))
                      * K_ADDR_WIDTH'(KERNEL_SIZE) + K_ADDR_WIDTH'(ky_q))
                     * K_ADDR_WIDTH'(KERNEL_SIZE) + K_ADDR_WIDTH'(kx_q);

  assign occupancy = {fifo_full, !fifo_full && !fifo_empty};
  assign slot_free = (occupancy + {1'b0, inflight_q}) < 2'd2;

  always_ff @(posedge clk or negedge arst_n_in) begin
    if (!arst_n_in) state_q <= IDLE;
    else            state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    busy    = 1'b0;
    done    = 1'b0;
    issue   = 1'b0;
    case (state_q)
      IDLE:   if (start) state_d = STREAM;
      STREAM: begin
        busy = 1'b1;
        if (slot_free) begin
          issue = 1'b1;
          if (last_beat) state_d = DRAIN;
        end
      end
      DRAIN: begin
        busy = 1'b1;
        if (fifo_empty && !inflight_q) state_d = DONE;
      end
      DONE: begin
        busy    = 1'b1;
        done    = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign fm_re   = issue && !pad;
  assign k_re    = issue;
  assign fm_addr = fm_re ? fm_addr_c : '0;
  assign k_addr  = issue ? k_addr_c : '0;

  // Each counter steps only when every inner counter wraps on this slot.
  always_ff @(posedge clk or negedge arst_n_in) begin
    if (!arst_n_in) begin
      x_q  <= '0;
      y_q  <= '0;
      ci_q <= '0;
      co_q <= '0;
      ky_q <= '0;
      kx_q <= '0;
    end else if (issue) begin
      kx_q <= kx_last ? '0 : kx_q + KW'(1);
      if (w_ky) ky_q <= ky_last ? '0 : ky_q + KW'(1);
      if (w_co) co_q <= co_last ? '0 : co_q + COW'(1);
      if (w_ci) ci_q <= ci_last ? '0 : ci_q + CIW'(1);
      if (w_y)  y_q  <= y_last  ? '0 : y_q + YW'(1);
      if (w_y && y_last) x_q <= x_last ? '0 : x_q + XW'(1);
    end
  end

  always_ff @(posedge clk or negedge arst_n_in) begin
    if (!arst_n_in) begin
      inflight_q <= 1'b0;
      pad_q      <= 1'b0;
    end else begin
      inflight_q <= issue;
      pad_q      <= issue && pad;
    end
  end

  assign a_in     = pad_q ? '0 : fm_rdata;
  assign fifo_pop = a_valid && a_ready && b_ready;

  feeder_skid_fifo #(
    .WIDTH(2 * DATA_WIDTH)
  ) u_fifo (
    .clk       (clk),
    .arst_n_in (arst_n_in),
    .push      (inflight_q),
    .wdata     ({a_in, k_rdata}),
    .pop       (fifo_pop),
    .rdata     (fifo_head),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  assign a_valid = !fifo_empty;
  assign b_valid = !fifo_empty;
  assign a_data  = fifo_empty ? '0 : fifo_head[2*DATA_WIDTH-1:DATA_WIDTH];
  assign b_data  = fifo_empty ? '0 : fifo_head[DATA_WIDTH-1:0];

endmodule

// File: tb/tb_conv_stream_feeder.sv
// Bench for conv_stream_feeder: two configurations against a loop-nest reference
// model of the tap order, with memories returning address+1.
module tb_conv_stream_feeder;

  localparam int unsigned DW  = 16;
  localparam int unsigned FAW = 26;
  localparam int unsigned KAW = 16;

  logic clk = 1'b0;
  logic arst_n;
  logic start [2];
  logic busy [2], done [2], fm_re [2], k_re [2];
  logic a_valid [2], b_valid [2], a_ready [2], b_ready [2];
  logic [FAW-1:0] fm_addr [2];
  logic [KAW-1:0] k_addr [2];
  logic [DW-1:0]  fm_rdata [2], k_rdata [2], a_data [2], b_data [2];

  int checks = 0;
  int errors = 0;

  logic [2*DW-1:0] exp_beat [2][$];
  logic [FAW-1:0]  exp_fm [2][$];
  logic [KAW-1:0]  exp_k [2][$];

  int issued [2], xfers [2], done_cnt [2];
  logic prev_stall [2];
  logic [DW-1:0] prev_a [2], prev_b [2];

  always #5 clk = ~clk;

  conv_stream_feeder #(
    .FEATURE_MAP_WIDTH(2), .FEATURE_MAP_HEIGHT(2), .INPUT_NB_CHANNELS(1),
    .OUTPUT_NB_CHANNELS(1), .KERNEL_SIZE(3), .DATA_WIDTH(DW),
    .FM_ADDR_WIDTH(FAW), .K_ADDR_WIDTH(KAW)
  ) dut_a (
    .clk(clk), .arst_n_in(arst_n), .start(start[0]), .busy(busy[0]), .done(done[0]),
    .fm_re(fm_re[0]), .fm_addr(fm_addr[0]), .fm_rdata(fm_rdata[0]),
    .k_re(k_re[0]), .k_addr(k_addr[0]), .k_rdata(k_rdata[0]),
    .a_valid(a_valid[0]), .b_valid(b_valid[0]), .a_data(a_data[0]), .b_data(b_data[0]),
    .a_ready(a_ready[0]), .b_ready(b_ready[0])
  );

  conv_stream_feeder #(
    .FEATURE_MAP_WIDTH(1), .FEATURE_MAP_HEIGHT(1), .INPUT_NB_CHANNELS(2),
    .OUTPUT_NB_CHANNELS(2), .KERNEL_SIZE(1), .DATA_WIDTH(DW),
    .FM_ADDR_WIDTH(FAW), .K_ADDR_WIDTH(KAW)
  ) dut_b (
    .clk(clk), .arst_n_in(arst_n), .start(start[1]), .busy(busy[1]), .done(done[1]),
    .fm_re(fm_re[1]), .fm_addr(fm_addr[1]), .fm_rdata(fm_rdata[1]),
    .k_re(k_re[1]), .k_addr(k_addr[1]), .k_rdata(k_rdata[1]),
    .a_valid(a_valid[1]), .b_valid(b_valid[1]), .a_data(a_data[1]), .b_data(b_data[1]),
    .a_ready(a_ready[1]), .b_ready(b_ready[1])
  );

  // Memories: fm[i] = i+1, kern[i] = i+1, one-cycle latency; junk when not read.
  always @(posedge clk) begin
    for (int i = 0; i < 2; i++) begin
      fm_rdata[i] <= fm_re[i] ? DW'(fm_addr[i] + FAW'(1)) : 16'hDEAD;
      k_rdata[i]  <= k_re[i]  ? DW'(k_addr[i] + KAW'(1))  : 16'hBEEF;
    end
  end

  task automatic check(input string nm, input int i, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s inst%0d: got %0h expected %0h", nm, i, act, exp);
    end
  endtask

  task automatic fail_now(input string nm, input int i);
    checks++;
    errors++;
    $display("FAIL %s inst%0d: got unexpected event expected none", nm, i);
  endtask

  task automatic build(input int idx, input int w, input int h, input int ci_n,
                       input int co_n, input int k);
    exp_beat[idx].delete();
    exp_fm[idx].delete();
    exp_k[idx].delete();
    for (int x = 0; x < w; x++)
      for (int y = 0; y < h; y++)
        for (int ci = 0; ci < ci_n; ci++)
          for (int co = 0; co < co_n; co++)
            for (int ky = 0; ky < k; ky++)
              for (int kx = 0; kx < k; kx++) begin
                int xi, yi, ka, fa;
                logic [DW-1:0] a;
                xi = x + kx - k / 2;
                yi = y + ky - k / 2;
                ka = ((co * ci_n + ci) * k + ky) * k + kx;
                if (xi < 0 || xi >= w || yi < 0 || yi >= h) a = '0;
                else begin
                  fa = (yi * w + xi) * ci_n + ci;
                  a  = DW'(fa + 1);
                  exp_fm[idx].push_back(FAW'(fa));
                end
                exp_k[idx].push_back(KAW'(ka));
                exp_beat[idx].push_back({a, DW'(ka + 1)});
              end
  endtask

  always @(negedge clk) begin
    for (int i = 0; i < 2; i++) begin
      if (!arst_n) begin
        check("reset_flags", i, 64'({busy[i], done[i], fm_re[i], k_re[i], a_valid[i], b_valid[i]}), 64'd0);
        check("reset_fm_addr", i, 64'(fm_addr[i]), 64'd0);
        check("reset_data", i, 64'({k_addr[i], a_data[i], b_data[i]}), 64'd0);
        prev_stall[i] = 1'b0;
        issued[i] = 0;
        xfers[i] = 0;
      end else begin
        logic xfer;
        xfer = a_valid[i] && a_ready[i] && b_ready[i];
        check("valid_pair", i, 64'(b_valid[i]), 64'(a_valid[i]));
        if (prev_stall[i])
          check("stall_hold", i, 64'({a_valid[i], a_data[i], b_data[i]}), 64'({1'b1, prev_a[i], prev_b[i]}));
        if (xfer) begin
          if (exp_beat[i].size() == 0) fail_now("extra_beat", i);
          else check("beat", i, 64'({a_data[i], b_data[i]}), 64'(exp_beat[i].pop_front()));
          xfers[i]++;
        end
        if (k_re[i]) begin
          if (exp_k[i].size() == 0) fail_now("extra_k_read", i);
          else check("k_addr", i, 64'(k_addr[i]), 64'(exp_k[i].pop_front()));
          issued[i]++;
        end
        if (fm_re[i]) begin
          check("fm_re_with_k_re", i, 64'(k_re[i]), 64'd1);
          if (exp_fm[i].size() == 0) fail_now("extra_fm_read", i);
          else check("fm_addr", i, 64'(fm_addr[i]), 64'(exp_fm[i].pop_front()));
        end
        check("outstanding_le2", i, 64'((issued[i] - xfers[i]) <= 2), 64'd1);
        if (done[i]) done_cnt[i]++;
        prev_stall[i] = a_valid[i] && !xfer;
        prev_a[i] = a_data[i];
        prev_b[i] = b_data[i];
      end
    end
  end

  function automatic logic ready_for(input int mode, input int c);
    case (mode)
      1:       return (c % 2) == 0;
      2:       return c >= 10;
      default: return 1'b1;
    endcase
  endfunction

  // mode 0: always ready, 1: toggling, 2: held low 10 cycles; retrig >= 0 re-pulses start mid-job.
  task automatic run_job(input int i, input int mode, input int retrig);
    int c, d0;
    d0 = done_cnt[i];
    @(posedge clk); #1;
    start[i] = 1'b1;
    a_ready[i] = (mode != 2);
    b_ready[i] = (mode != 2);
    @(posedge clk); #1;
    start[i] = 1'b0;
    check("busy_after_start", i, 64'(busy[i]), 64'd1);
    c = 0;
    while (done_cnt[i] == d0 && c < 3000) begin
      a_ready[i] = ready_for(mode, c);
      b_ready[i] = ready_for(mode, c);
      start[i] = (c == retrig);
      if (mode == 2 && c == 9) check("stall_slots", i, 64'(issued[i] - xfers[i]), 64'd2);
      @(posedge clk); #1;
      c++;
    end
    start[i] = 1'b0;
    a_ready[i] = 1'b1;
    b_ready[i] = 1'b1;
    if (c >= 3000) fail_now("done_timeout", i);
    check("busy_after_done", i, 64'(busy[i]), 64'd0);
    repeat (6) @(posedge clk);
    #1;
    check("done_once", i, 64'(done_cnt[i] - d0), 64'd1);
    check("beats_left", i, 64'(exp_beat[i].size()), 64'd0);
    check("reads_left", i, 64'(exp_fm[i].size() + exp_k[i].size()), 64'd0);
  endtask

  initial begin
    logic [KAW-1:0] kb [4];
    logic [FAW-1:0] fb [4];
    int x0, c;
    kb = '{16'd0, 16'd2, 16'd1, 16'd3};
    fb = '{26'd0, 26'd0, 26'd1, 26'd1};
    arst_n = 1'b0;
    for (int i = 0; i < 2; i++) begin
      start[i] = 1'b0;
      a_ready[i] = 1'b1;
      b_ready[i] = 1'b1;
      done_cnt[i] = 0;
    end
    repeat (3) @(posedge clk);
    #1 arst_n = 1'b1;

    build(0, 2, 2, 1, 1, 3);
    check("model_len", 0, 64'(exp_beat[0].size()), 64'd36);
    check("model_beat0", 0, 64'(exp_beat[0][0]), 64'h0000_0001);
    check("model_beat4", 0, 64'(exp_beat[0][4]), 64'h0001_0005);
    check("model_beat8", 0, 64'(exp_beat[0][8]), 64'h0004_0009);
    run_job(0, 0, -1);

    build(0, 2, 2, 1, 1, 3);
    run_job(0, 1, -1);

    build(0, 2, 2, 1, 1, 3);
    run_job(0, 2, -1);

    build(1, 1, 1, 2, 2, 1);
    check("model_b_len", 1, 64'(exp_k[1].size()), 64'd4);
    for (int j = 0; j < 4; j++) begin
      check("model_b_k", 1, 64'(exp_k[1][j]), 64'(kb[j]));
      check("model_b_fm", 1, 64'(exp_fm[1][j]), 64'(fb[j]));
    end
    run_job(1, 0, -1);

    // Abandon a job at beat 10 with an asynchronous reset, then rerun from scratch.
    build(0, 2, 2, 1, 1, 3);
    x0 = xfers[0];
    @(posedge clk); #1;
    start[0] = 1'b1;
    @(posedge clk); #1;
    start[0] = 1'b0;
    c = 0;
    while (xfers[0] - x0 < 10 && c < 500) begin
      @(posedge clk); #1;
      c++;
    end
    if (c >= 500) fail_now("beat10_timeout", 0);
    #2 arst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    build(0, 2, 2, 1, 1, 3);
    arst_n = 1'b1;
    run_job(0, 0, -1);

    build(0, 2, 2, 1, 1, 3);
    run_job(0, 0, 20);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/conv_stream_feeder.md
CONV_STREAM_FEEDER -- requirements
Module: conv_stream_feeder

Interface
REQ-001 Params (name, default, meaning):
- FEATURE_MAP_WIDTH, 1024, pixels per row
- FEATURE_MAP_HEIGHT, 1024, rows
- INPUT_NB_CHANNELS, 64, input channels
- OUTPUT_NB_CHANNELS, 64, output channels
- KERNEL_SIZE, 3, odd kernel edge
- DATA_WIDTH, 16, operand width
- FM_ADDR_WIDTH, 26, feature-map memory address width
- K_ADDR_WIDTH, 16, kernel memory address width
REQ-002 Clock and reset: reset arst_n_in, asynchronous, active-low; clock clk.
REQ-003 Ports (name, direction, width, meaning):
- clk  in  1  clock
- arst_n_in  in  1  async reset, active low
- start  in  1  one-cycle job request
- busy  out  1  job in progress
- done  out  1  one-cycle pulse after last beat accepted
- fm_re  out  1  feature-map read enable
- fm_addr  out  FM_ADDR_WIDTH  feature-map read address
- fm_rdata  in  DATA_WIDTH  feature-map data, valid 1 cycle after fm_re
- k_re  out  1  kernel read enable
- k_addr  out  K_ADDR_WIDTH  kernel read address
- k_rdata  in  DATA_WIDTH  kernel data, valid 1 cycle after k_re
- a_valid, b_valid  out  1  operand beat valid (always equal)
- a_data, b_data  out  DATA_WIDTH  activation / weight
- a_ready, b_ready  in  1  consumer readiness

Function
REQ-004 Beat order SHALL be: for x, for y, for ch_in, for ch_out, for ky, for kx (kx innermost); total beats = W*H*Cin*Cout*K*K.
REQ-005 Per beat: xi = x+kx-K/2, yi = y+ky-K/2; if xi or yi is outside [0,W-1]/[0,H-1], a_data SHALL be 0 and no fm read SHALL be issued.
REQ-006 fm_addr SHALL = (yi*W + xi)*Cin + ch_in; k_addr SHALL = ((ch_out*Cin + ch_in)*K + ky)*K + kx.
REQ-007 Beats SHALL be buffered in a 2-entry FIFO; a memory-read (or padded) slot SHALL be issued only when occupancy + in-flight < 2.
REQ-008 A beat transfers on a cycle with a_valid && a_ready && b_ready; a_valid and b_valid SHALL stay asserted and data stable until transfer.
REQ-009 When the FIFO is non-empty and the consumer is ready, the FIFO SHALL sustain one transfer per cycle.
REQ-010 FSM states: IDLE -> (start) STREAM -> (last beat issued) DRAIN -> (FIFO empty) DONE -> IDLE; DONE lasts exactly 1 cycle and asserts done.
REQ-011 busy SHALL be 1 in STREAM, DRAIN, DONE; start SHALL be ignored unless state is IDLE.
REQ-012 fm_re/k_re SHALL be 1 for exactly one cycle per issued slot; k_re SHALL be issued for every beat, including padded ones.
REQ-013 Loop counters SHALL wrap to 0 after their last value, and each outer counter SHALL advance only on the inner wrap.
REQ-014 Address arithmetic SHALL be unsigned; signed xi/yi SHALL be one bit wider than the x/y counters.

Reset
REQ-015 Assertion of arst_n_in SHALL immediately force: state IDLE, counters 0, FIFO empty, in-flight cleared; busy, done, fm_re, k_re, a_valid, b_valid 0; addresses and data 0.
REQ-016 Reset mid-job SHALL abandon the job; no beat from the abandoned job SHALL appear after reset release.

Structure
REQ-017 Package conv_pkg SHALL hold the default dimension constants and the feeder_state_t enum {IDLE, STREAM, DRAIN, DONE}.
REQ-018 The 2-entry FIFO SHALL be sub-module feeder_skid_fifo (width 2*DATA_WIDTH, push/pop, full/empty flags).

Verification
All cases use fm[i]=i+1 and kern[i]=i+1.
REQ-019 W=H=2, Cin=Cout=1, K=3, a_ready=b_ready=1 -> 36 beats, then one done pulse. Beat 0: (a,b)=(0,1). Beat 4: (1,5). Beat 8: (4,9).
REQ-020 Same configuration, ready toggling 1/0 each cycle -> identical 36-beat sequence; data stable while stalled; no beat lost or duplicated.
REQ-021 Same configuration, ready held 0 for 10 cycles after start -> at most 2 fm reads outstanding; a_valid high and data unchanged for the whole stall.
REQ-022 W=H=1, Cin=2, Cout=2, K=1 -> 4 beats with k_addr 0, 2, 1, 3 and fm_addr 0, 0, 1, 1.
REQ-023 arst_n_in pulsed low at beat 10, then start -> outputs 0 during reset; the new job restarts from beat 0 with (a,b)=(0,1).
REQ-024 start asserted while busy -> ignored; exactly one done pulse occurs.
